// File: rtl/local_mem_result_buf.sv
// Output-stage result buffer: DEPTH signed words with overwrite or saturating
// accumulate writes, registered reads, a sticky overflow flag and a sequential clear.
module local_mem_result_buf #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_result_signal,
  input  logic [ADDR_WIDTH-1:0] write_result_addr,
  input  logic [DATA_WIDTH-1:0] write_result_data,
  input  logic                  write_result_accum,
  input  logic                  read_result_signal,
  input  logic [ADDR_WIDTH-1:0] read_result_addr,
  input  logic                  clear_signal,
  output logic [DATA_WIDTH-1:0] read_result_data,
  output logic                  read_result_valid,
  output logic                  busy,
  output logic                  accum_overflow
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH-1);
  localparam logic [DATA_WIDTH-1:0] MAXV    = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] MINV    = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  start_clr, wr_in_range, rd_in_range, wr_en, rd_en;
  logic                  ovf_pos, ovf_neg;
  logic [DATA_WIDTH-1:0] cur, wdata;
  logic [DATA_WIDTH:0]   sum;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clear_signal) state_nxt = CLEAR;
      CLEAR:   if (cnt == LAST)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == CLEAR);
  end

  // ---------------- write datapath ----------------
  assign start_clr   = (state == IDLE) && clear_signal;
  assign wr_in_range = {1'b0, write_result_addr} < DEPTH_W;
  assign rd_in_range = {1'b0, read_result_addr} < DEPTH_W;
  // Clear wins over a write sampled in the same cycle.
  assign wr_en = write_result_signal && (state == IDLE) && !clear_signal && wr_in_range;
  assign rd_en = read_result_signal && (state == IDLE) && rd_in_range;

  always_comb begin
    cur     = wr_in_range ? mem[write_result_addr] : '0;
    sum     = {cur[DATA_WIDTH-1], cur} + {write_result_data[DATA_WIDTH-1], write_result_data};
    ovf_pos = !sum[DATA_WIDTH] &&  sum[DATA_WIDTH-1];
    ovf_neg =  sum[DATA_WIDTH] && !sum[DATA_WIDTH-1];
    if (!write_result_accum) wdata = write_result_data;
    else if (ovf_pos)        wdata = MAXV;
    else if (ovf_neg)        wdata = MINV;
    else                     wdata = sum[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (state == CLEAR) begin
      mem[cnt] <= '0;
    end else if (wr_en) begin
      mem[write_result_addr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                cnt <= '0;
    else if (start_clr)      cnt <= '0;
    else if (state == CLEAR) cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                           accum_overflow <= 1'b0;
    else if (start_clr)                                 accum_overflow <= 1'b0;
    else if (wr_en && write_result_accum && (ovf_pos || ovf_neg)) accum_overflow <= 1'b1;
  end

  // ---------------- read port ----------------
  // Registered read of the pre-write array contents gives read-first collisions.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      read_result_data  <= '0;
      read_result_valid <= 1'b0;
    end else begin
      read_result_data  <= rd_en ? mem[read_result_addr] : '0;
      read_result_valid <= rd_en;
    end
  end

endmodule

// File: tb/tb_local_mem_result_buf.sv
// Directed bench for local_mem_result_buf: a DEPTH=64 instance for the main
// function and a DEPTH=48 instance for non-power-of-two bounds.
module tb_local_mem_result_buf;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_sig = 0, wr_acc = 0, rd_sig = 0, clr = 0;
  logic [5:0]  wr_addr = 0, rd_addr = 0;
  logic [31:0] wr_data = 0;
  logic [31:0] rd_data;
  logic        rd_vld, busy, ovf;

  logic        b_wr_sig = 0, b_rd_sig = 0, b_clr = 0;
  logic [5:0]  b_wr_addr = 0, b_rd_addr = 0;
  logic [31:0] b_wr_data = 0;
  logic [31:0] b_rd_data;
  logic        b_rd_vld, b_busy, b_ovf;

  int vectors = 0;
  int miscompares = 0;
  int busy_cycles;

  always #5 clk = ~clk;

  local_mem_result_buf #(.DATA_WIDTH(32), .DEPTH(64)) u_dut (
    .clk(clk), .rst(rst),
    .write_result_signal(wr_sig), .write_result_addr(wr_addr),
    .write_result_data(wr_data), .write_result_accum(wr_acc),
    .read_result_signal(rd_sig), .read_result_addr(rd_addr),
    .clear_signal(clr),
    .read_result_data(rd_data), .read_result_valid(rd_vld),
    .busy(busy), .accum_overflow(ovf)
  );

  local_mem_result_buf #(.DATA_WIDTH(32), .DEPTH(48)) u_dut48 (
    .clk(clk), .rst(rst),
    .write_result_signal(b_wr_sig), .write_result_addr(b_wr_addr),
    .write_result_data(b_wr_data), .write_result_accum(1'b0),
    .read_result_signal(b_rd_sig), .read_result_addr(b_rd_addr),
    .clear_signal(b_clr),
    .read_result_data(b_rd_data), .read_result_valid(b_rd_vld),
    .busy(b_busy), .accum_overflow(b_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic acc);
    wr_sig = 1; wr_addr = a; wr_data = d; wr_acc = acc;
    tick();
    wr_sig = 0; wr_acc = 0;
  endtask

  task automatic rd(input string tag, input logic [5:0] a, input logic [31:0] exp);
    rd_sig = 1; rd_addr = a;
    tick();
    rd_sig = 0;
    chk({tag, "_data"}, rd_data, exp);
    chk({tag, "_vld"}, {31'd0, rd_vld}, 32'd1);
  endtask

  initial begin
    // reset state
    #12;
    chk("rst_data", rd_data, 32'd0);
    chk("rst_vld", {31'd0, rd_vld}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    @(negedge clk); rst = 1;
    tick();

    // overwrite then read, valid lasts one cycle
    wr(6'd5, 32'h0000_1234, 1'b0);
    rd("rd5", 6'd5, 32'h0000_1234);
    tick();
    chk("rd5_after_data", rd_data, 32'd0);
    chk("rd5_after_vld", {31'd0, rd_vld}, 32'd0);

    // accumulate without saturation
    wr(6'd3, 32'd10, 1'b0);
    wr(6'd3, -32'sd15, 1'b1);
    rd("acc3", 6'd3, 32'hFFFF_FFFB);
    chk("acc3_ovf", {31'd0, ovf}, 32'd0);

    // positive saturation, sticky flag
    wr(6'd7, 32'h7FFF_FFF0, 1'b0);
    wr(6'd7, 32'h0000_0020, 1'b1);
    rd("sat7", 6'd7, 32'h7FFF_FFFF);
    chk("sat7_ovf", {31'd0, ovf}, 32'd1);
    tick(); tick();
    chk("sat7_ovf_sticky", {31'd0, ovf}, 32'd1);

    // negative saturation
    wr(6'd8, 32'h8000_0010, 1'b0);
    wr(6'd8, 32'hFFFF_FFE0, 1'b1);
    rd("sat8", 6'd8, 32'h8000_0000);

    // read-first collision
    wr(6'd2, 32'd1, 1'b0);
    wr_sig = 1; wr_addr = 6'd2; wr_data = 32'd9; rd_sig = 1; rd_addr = 6'd2;
    tick();
    wr_sig = 0; rd_sig = 0;
    chk("coll_old", rd_data, 32'd1);
    rd("coll_new", 6'd2, 32'd9);

    // fill all entries, then clear together with a write to addr 4
    for (int i = 0; i < 64; i++) wr(6'(i), 32'(i + 100), 1'b0);
    clr = 1; wr_sig = 1; wr_addr = 6'd4; wr_data = 32'hAA;
    tick();
    clr = 0; wr_sig = 0;
    chk("clr_busy_start", {31'd0, busy}, 32'd1);
    chk("clr_ovf_drop", {31'd0, ovf}, 32'd0);
    busy_cycles = 1;
    for (int i = 0; i < 70; i++) begin
      if (i == 4) begin
        wr_sig = 1; wr_addr = 6'd0; wr_data = 32'h55; rd_sig = 1; rd_addr = 6'd10;
      end
      tick();
      if (i == 4) begin
        wr_sig = 0; rd_sig = 0;
        chk("clr_rd_drop_vld", {31'd0, rd_vld}, 32'd0);
      end
      if (busy) busy_cycles++;
    end
    chk("clr_busy_cycles", 32'(busy_cycles), 32'd64);
    chk("clr_busy_end", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 64; i++) rd($sformatf("clr_rd%0d", i), 6'(i), 32'd0);

    // non-power-of-two depth: out-of-range access dropped, last entry usable
    b_wr_sig = 1; b_wr_addr = 6'd50; b_wr_data = 32'h99;
    tick();
    b_wr_addr = 6'd47; b_wr_data = 32'h4747;
    tick();
    b_wr_sig = 0;
    b_rd_sig = 1; b_rd_addr = 6'd50;
    tick();
    chk("d48_oob_vld", {31'd0, b_rd_vld}, 32'd0);
    chk("d48_oob_data", b_rd_data, 32'd0);
    b_rd_addr = 6'd47;
    tick();
    b_rd_sig = 0;
    chk("d48_rd47_data", b_rd_data, 32'h4747);
    chk("d48_rd47_vld", {31'd0, b_rd_vld}, 32'd1);
    b_clr = 1;
    tick();
    b_clr = 0;
    busy_cycles = b_busy ? 1 : 0;
    for (int i = 0; i < 55; i++) begin
      tick();
      if (b_busy) busy_cycles++;
    end
    chk("d48_busy_cycles", 32'(busy_cycles), 32'd48);
    b_rd_sig = 1; b_rd_addr = 6'd47;
    tick();
    b_rd_sig = 0;
    chk("d48_clr47", b_rd_data, 32'd0);
    chk("d48_clr47_vld", {31'd0, b_rd_vld}, 32'd1);

    // reset in the middle of a clear
    wr(6'd60, 32'h77, 1'b0);
    rd("pre_rst60", 6'd60, 32'h77);
    clr = 1;
    tick();
    clr = 0;
    for (int i = 0; i < 10; i++) tick();
    chk("midclr_busy", {31'd0, busy}, 32'd1);
    rst = 0;
    #1;
    chk("rst_busy_now", {31'd0, busy}, 32'd0);
    @(negedge clk); rst = 1;
    tick();
    rd("post_rst60", 6'd60, 32'd0);
    rd("post_rst20", 6'd20, 32'd0);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
